// File: rtl/acc_wb_pkg.sv
// Shared types for the accumulator write-back path: data width, FSM states and the FIFO entry layout.
package acc_wb_pkg;

  localparam int ACC_W        = 8;
  localparam int ENTRY_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ACC_W-1:0]        data;
  } acc_entry_t;

endpackage

// File: rtl/acc_wb_fifo.sv
// Small synchronous FIFO with async reset on the pointers/count; the storage array is data only.
module acc_wb_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  // Admission uses pre-edge full/empty, so a same-cycle pop never frees room for a push.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/acc_writeback.sv
// Accumulator store drain: queues {addr, acc} on store and writes each entry to data memory over req/ack.
// Optional ACC_WB_READBACK_EN adds a read-back verify of every write.
module acc_writeback
  import acc_wb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ACC_W-1:0]       acc_in,
  input  logic                   store,
  input  logic [ADDR_W-1:0]      store_addr,
  input  logic                   clear_err,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow_err,
  output logic                   mismatch_err,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [ACC_W-1:0]       mem_wdata,
  input  logic [ACC_W-1:0]       mem_rdata,
  input  logic                   mem_ack
);

  localparam int ENT_W = ADDR_W + ACC_W;

  state_t           state;
  state_t           state_nxt;
  logic             pop;
  logic [ENT_W-1:0] head;
  logic [ADDR_W-1:0] head_addr;
  logic [ACC_W-1:0]  head_data;

  acc_wb_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (store),
    .pop   (pop),
    .din   ({store_addr, acc_in}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign head_addr = head[ENT_W-1:ACC_W];
  assign head_data = head[ACC_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!empty) state_nxt = WRITE;
`ifdef ACC_WB_READBACK_EN
      WRITE: if (mem_ack) state_nxt = READ;
      READ:  if (mem_ack) state_nxt = IDLE;
`else
      WRITE: if (mem_ack) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data are gated by the request so they read 0 while idle instead of stale FIFO contents.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pop       = 1'b0;
    case (state)
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
`ifndef ACC_WB_READBACK_EN
        pop       = mem_ack;
`endif
      end
`ifdef ACC_WB_READBACK_EN
      READ: begin
        mem_req  = 1'b1;
        mem_addr = head_addr;
        pop      = mem_ack;
      end
`endif
      default: ;
    endcase
  end

  // Sticky flags: a fresh error in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) overflow_err <= 1'b0;
    else       overflow_err <= (store & full) | (overflow_err & ~clear_err);
  end

`ifdef ACC_WB_READBACK_EN
  logic mismatch_set;
  assign mismatch_set = (state == READ) & mem_ack & (mem_rdata != head_data);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) mismatch_err <= 1'b0;
    else       mismatch_err <= mismatch_set | (mismatch_err & ~clear_err);
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mismatch_err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_writeback.sv
// Scoreboard bench for acc_writeback: expected writes queued at store time, checked by a memory-side monitor.
module tb_acc_writeback;
  import acc_wb_pkg::*;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic [7:0] acc_in;
  logic       store;
  logic [7:0] store_addr;
  logic       clear_err;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       overflow_err;
  logic       mismatch_err;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  int checks = 0;
  int errors = 0;
  acc_entry_t exp_q[$];

  acc_writeback #(.ADDR_W(8), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .acc_in       (acc_in),
    .store        (store),
    .store_addr   (store_addr),
    .clear_err    (clear_err),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow_err (overflow_err),
    .mismatch_err (mismatch_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_store(input logic [7:0] a, input logic [7:0] d, input bit expect_admit);
    acc_entry_t e;
    store = 1'b1;
    store_addr = a;
    acc_in = d;
    if (expect_admit) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    tick();
    store = 1'b0;
  endtask

  task automatic do_ack(input logic [7:0] rd);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    if (!mem_req) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: mem_req got 0 expected 1");
    end
    mem_ack = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
`ifdef ACC_WB_READBACK_EN
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
`endif
  endtask

  // Memory-side monitor: every write cycle must present the oldest outstanding entry.
  always @(negedge clock) begin
    if (!reset && mem_req && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        check("wr_addr", {8'h0, mem_addr}, {8'h0, exp_q[0].addr});
        check("wr_data", {8'h0, mem_wdata}, {8'h0, exp_q[0].data});
        if (mem_ack) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    acc_in = '0;
    store = 1'b0;
    store_addr = '0;
    clear_err = 1'b0;
    mem_rdata = '0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_empty", {15'h0, empty}, 16'h1);
    check("rst_level", {13'h0, level}, 16'h0);
    check("rst_req", {15'h0, mem_req}, 16'h0);
    check("rst_ovf", {15'h0, overflow_err}, 16'h0);
    reset = 1'b0;
    tick();

    // 1: single store, ack three cycles after the request appears
    do_store(8'h10, 8'h2A, 1'b1);
    check("t1_req_n", {15'h0, mem_req}, 16'h0);
    check("t1_level", {13'h0, level}, 16'h1);
    tick();
    check("t1_req_n1", {15'h0, mem_req}, 16'h1);
    check("t1_we", {15'h0, mem_we}, 16'h1);
    check("t1_addr", {8'h0, mem_addr}, 16'h10);
    tick();
    tick();
    do_ack(8'h2A);
    check("t1_empty", {15'h0, empty}, 16'h1);
    check("t1_req_done", {15'h0, mem_req}, 16'h0);

    // 2: DEPTH+1 stores with no ack; the last one is dropped
    for (int i = 0; i < DEPTH + 1; i++)
      do_store(8'h20 + 8'(i), 8'h11 + 8'(i), i < DEPTH);
    check("t2_full", {15'h0, full}, 16'h1);
    check("t2_level", {13'h0, level}, 16'h4);
    check("t2_ovf", {15'h0, overflow_err}, 16'h1);
    for (int i = 0; i < DEPTH; i++) do_ack(8'h11 + 8'(i));
    check("t2_empty", {15'h0, empty}, 16'h1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t2_clr", {15'h0, overflow_err}, 16'h0);

    // 3: store while full coincident with the popping ack
    for (int i = 0; i < DEPTH; i++)
      do_store(8'h50 + 8'(i), 8'h41 + 8'(i), 1'b1);
    check("t3_full", {15'h0, full}, 16'h1);
`ifdef ACC_WB_READBACK_EN
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
`endif
    store = 1'b1;
    store_addr = 8'h5F;
    acc_in = 8'h99;
    mem_ack = 1'b1;
    mem_rdata = 8'h41;
    tick();
    store = 1'b0;
    mem_ack = 1'b0;
    check("t3_level", {13'h0, level}, 16'h3);
    check("t3_ovf", {15'h0, overflow_err}, 16'h1);
    for (int i = 1; i < DEPTH; i++) do_ack(8'h41 + 8'(i));
    check("t3_empty", {15'h0, empty}, 16'h1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;

    // 6: clear_err in the same cycle as an overflow drop
    for (int i = 0; i < DEPTH; i++)
      do_store(8'h70 + 8'(i), 8'h61 + 8'(i), 1'b1);
    store = 1'b1;
    store_addr = 8'h7F;
    acc_in = 8'hEE;
    clear_err = 1'b1;
    tick();
    store = 1'b0;
    check("t6_ovf_wins", {15'h0, overflow_err}, 16'h1);
    tick();
    clear_err = 1'b0;
    check("t6_ovf_clr", {15'h0, overflow_err}, 16'h0);

    // 4: async reset while a write is outstanding
    do_store(8'h7E, 8'hDD, 1'b0);
    check("t4_ovf_pre", {15'h0, overflow_err}, 16'h1);
    check("t4_req_pre", {15'h0, mem_req}, 16'h1);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("t4_req", {15'h0, mem_req}, 16'h0);
    check("t4_empty", {15'h0, empty}, 16'h1);
    check("t4_level", {13'h0, level}, 16'h0);
    check("t4_ovf", {15'h0, overflow_err}, 16'h0);
    check("t4_mis", {15'h0, mismatch_err}, 16'h0);
    tick();
    reset = 1'b0;
    tick();

`ifdef ACC_WB_READBACK_EN
    // 5: read-back mismatch
    do_store(8'h30, 8'h55, 1'b1);
    tick();
    check("t5_we_w", {15'h0, mem_we}, 16'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t5_req_r", {15'h0, mem_req}, 16'h1);
    check("t5_we_r", {15'h0, mem_we}, 16'h0);
    check("t5_addr_r", {8'h0, mem_addr}, 16'h30);
    mem_ack = 1'b1;
    mem_rdata = 8'h54;
    tick();
    mem_ack = 1'b0;
    check("t5_mis", {15'h0, mismatch_err}, 16'h1);
    check("t5_empty", {15'h0, empty}, 16'h1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t5_mis_clr", {15'h0, mismatch_err}, 16'h0);
`else
    check("t5_mis_tied", {15'h0, mismatch_err}, 16'h0);
`endif

    repeat (3) tick();
    check("sb_drained", 16'(exp_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
